// File: rtl/mic_dma_pkg.sv
// Shared types and constants for the microphone capture DMA engine.
// The optional second microphone pair is enabled by defining MIC_DMA_DUAL_MIC_EN.
package mic_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_SEL_A,
    ST_WRITE_A,
    ST_SEL_B,
    ST_WRITE_B,
    ST_DONE
  } mic_dma_state_t;

  localparam logic [1:0]  SEL_MIC_A  = 2'd2;
  localparam logic [1:0]  SEL_MIC_B  = 2'd1;
  localparam logic [1:0]  SEL_IDLE   = 2'd0;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Mux setting that must be presented while the engine is in state s.
  // The select is held through the write so the captured pair stays obvious on a scope.
  function automatic logic [1:0] state_select(input mic_dma_state_t s);
    case (s)
      ST_SEL_A, ST_WRITE_A: return SEL_MIC_A;
      ST_SEL_B, ST_WRITE_B: return SEL_MIC_B;
      default:              return SEL_IDLE;
    endcase
  endfunction

  // States in which a new frame cannot be accepted.
  function automatic logic is_busy(input mic_dma_state_t s);
    return (s == ST_SEL_A) || (s == ST_WRITE_A) || (s == ST_SEL_B) || (s == ST_WRITE_B);
  endfunction

  // States that present a write request on the bus.
  function automatic logic is_write(input mic_dma_state_t s);
    return (s == ST_WRITE_A) || (s == ST_WRITE_B);
  endfunction

endpackage

// File: rtl/start_edge_detect.sv
// Registered 0->1 detector for the level-sensitive start input.
// The pulse appears in the cycle after start is first seen high.
module start_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  output logic rise
);

  logic start_q;

  // Track the previous start level and register the rising-edge pulse
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // Pretend start was already high: a start held through reset must drop
      // and rise again before it launches a run.
      start_q <= 1'b1;
      rise    <= 1'b0;
    end else begin
      start_q <= start;
      rise    <= start & ~start_q;
    end
  end

endmodule

// File: rtl/mic_sample_dma.sv
// Avalon-MM write-master DMA: streams captured microphone frames into
// consecutive words of system memory, one frame per read_ready strobe.
// Define MIC_DMA_DUAL_MIC_EN to write pair A and pair B for every frame;
// otherwise only pair A is written.
module mic_sample_dma
  import mic_dma_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] AM_ADDR,
  output logic [2:0]  AM_BURSTCOUNT,
  output logic        AM_WRITE,
  output logic [31:0] AM_WRITEDATA,
  output logic [3:0]  AM_BYTEENABLE,
  input  logic        AM_WAITREQUEST,
  input  logic [31:0] mic_data,
  output logic [1:0]  select,
  input  logic        start,
  input  logic        read_ready,
  input  logic [31:0] start_address,
  input  logic [31:0] number_samples,
  output logic        FINISHED,
  output logic        OVERRUN
);

  mic_dma_state_t state, state_d;
  logic [31:0]    count;
  logic           start_rise;
  logic           launch;
  logic           capture;
  logic           accept;
  logic           frame_done;
  logic           last_frame;

  assign AM_BURSTCOUNT = 3'd1;
  assign AM_BYTEENABLE = 4'hF;
  assign last_frame    = (count == 32'd1);

  start_edge_detect u_start_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .rise  (start_rise)
  );

  // Next-state logic and the datapath strobes for this cycle
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state;
    launch     = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_rise) begin
          launch  = 1'b1;
          state_d = (number_samples == 32'd0) ? ST_DONE : ST_WAIT_READY;
        end
      end
      ST_WAIT_READY: begin
        if (read_ready) state_d = ST_SEL_A;
      end
      ST_SEL_A: begin
        capture = 1'b1;
        state_d = ST_WRITE_A;
      end
      ST_WRITE_A: begin
        if (!AM_WAITREQUEST) begin
          accept = 1'b1;
`ifdef MIC_DMA_DUAL_MIC_EN
          state_d = ST_SEL_B;
`else
          frame_done = 1'b1;
          state_d    = last_frame ? ST_DONE : ST_WAIT_READY;
`endif
        end
      end
`ifdef MIC_DMA_DUAL_MIC_EN
      ST_SEL_B: begin
        capture = 1'b1;
        state_d = ST_WRITE_B;
      end
      ST_WRITE_B: begin
        if (!AM_WAITREQUEST) begin
          accept     = 1'b1;
          frame_done = 1'b1;
          state_d    = last_frame ? ST_DONE : ST_WAIT_READY;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any run in progress
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Control outputs are registered copies of what the next state demands
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      select   <= SEL_IDLE;
      AM_WRITE <= 1'b0;
      FINISHED <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      select   <= state_select(state_d);
      AM_WRITE <= is_write(state_d);
      FINISHED <= (state_d == ST_DONE);
      if (launch)                             OVERRUN <= 1'b0;
      else if (read_ready && is_busy(state))  OVERRUN <= 1'b1;
    end
  end

  // Address, remaining-frame count and captured data
  // NOTE: these are plain registers, so all of them reset; only true RAM arrays may skip reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      AM_ADDR      <= 32'd0;
      AM_WRITEDATA <= 32'd0;
      count        <= 32'd0;
    end else begin
      if (launch)      AM_ADDR <= start_address & ~32'd3;
      else if (accept) AM_ADDR <= AM_ADDR + WORD_BYTES;

      if (launch)          count <= number_samples;
      else if (frame_done) count <= count - 32'd1;

      if (capture) AM_WRITEDATA <= mic_data;
    end
  end

endmodule

// File: tb/tb_mic_sample_dma.sv
// Self-checking bench for mic_sample_dma: directed scenarios with random
// frame contents, compared against a queue of expected (address, data) writes.
module tb_mic_sample_dma;

`ifdef MIC_DMA_DUAL_MIC_EN
  localparam int WPF = 2;
`else
  localparam int WPF = 1;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK;
  logic        RESET;
  logic [31:0] AM_ADDR;
  logic [2:0]  AM_BURSTCOUNT;
  logic        AM_WRITE;
  logic [31:0] AM_WRITEDATA;
  logic [3:0]  AM_BYTEENABLE;
  logic        AM_WAITREQUEST;
  logic [31:0] mic_data;
  logic [1:0]  select;
  logic        start;
  logic        read_ready;
  logic [31:0] start_address;
  logic [31:0] number_samples;
  logic        FINISHED;
  logic        OVERRUN;

  logic [31:0] frame_a;
  logic [31:0] frame_b;
  logic [31:0] model_addr;
  wr_t         exp_q[$];
  int          accepted;
  int          n_cmp;
  int          n_err;
  logic        saw_write;

  // External capture mux driven by the DUT's select.
  assign mic_data = (select == 2'd2) ? frame_a : (select == 2'd1) ? frame_b : 32'h0;

  mic_sample_dma dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .AM_ADDR        (AM_ADDR),
    .AM_BURSTCOUNT  (AM_BURSTCOUNT),
    .AM_WRITE       (AM_WRITE),
    .AM_WRITEDATA   (AM_WRITEDATA),
    .AM_BYTEENABLE  (AM_BYTEENABLE),
    .AM_WAITREQUEST (AM_WAITREQUEST),
    .mic_data       (mic_data),
    .select         (select),
    .start          (start),
    .read_ready     (read_ready),
    .start_address  (start_address),
    .number_samples (number_samples),
    .FINISHED       (FINISHED),
    .OVERRUN        (OVERRUN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: watch the bus at the falling edge, return just after the next rising edge.
  task automatic step();
    wr_t e;
    @(negedge CLK);
    if (AM_WRITE === 1'b1) saw_write = 1'b1;
    if (AM_WRITE === 1'b1 && AM_WAITREQUEST === 1'b0) begin
      accepted++;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL spurious_write: observed write to 0x%08h expected none", AM_ADDR);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", AM_ADDR, e.addr);
        check("wr_data", AM_WRITEDATA, e.data);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    RESET          = 1'b0;
    start          = 1'b0;
    read_ready     = 1'b0;
    AM_WAITREQUEST = 1'b0;
    steps(3);
    RESET = 1'b1;
    exp_q.delete();
    step();
  endtask

  // Raise start; returns two cycles after the edge, when the run is armed.
  task automatic launch(input logic [31:0] addr, input logic [31:0] n);
    start = 1'b0;
    step();
    start_address  = addr;
    number_samples = n;
    start          = 1'b1;
    steps(2);
    model_addr = addr & 32'hFFFF_FFFC;
    accepted   = 0;
    exp_q.delete();
  endtask

  // Present one fresh frame with a single read_ready strobe; returns one cycle later.
  task automatic pulse_frame();
    frame_a = $urandom;
    frame_b = $urandom;
    exp_q.push_back('{addr: model_addr, data: frame_a});
    model_addr = model_addr + 32'd4;
    if (WPF == 2) begin
      exp_q.push_back('{addr: model_addr, data: frame_b});
      model_addr = model_addr + 32'd4;
    end
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
  endtask

  // Run until every expected word has been written, within a cycle budget.
  task automatic drain(input bit rnd_wait);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 80) begin
      AM_WAITREQUEST = rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      budget++;
    end
    AM_WAITREQUEST = 1'b0;
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL drain_timeout: observed %0d words outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    accepted       = 0;
    saw_write      = 1'b0;
    frame_a        = 32'h0;
    frame_b        = 32'h0;
    model_addr     = 32'h0;
    start_address  = 32'h0;
    number_samples = 32'h0;
    RESET          = 1'b0;
    do_reset();

    // Reset values
    check("rst_addr", AM_ADDR, 32'h0);
    check("rst_write", 32'(AM_WRITE), 32'h0);
    check("rst_wdata", AM_WRITEDATA, 32'h0);
    check("rst_select", 32'(select), 32'h0);
    check("rst_finished", 32'(FINISHED), 32'h0);
    check("rst_overrun", 32'(OVERRUN), 32'h0);
    check("burstcount", 32'(AM_BURSTCOUNT), 32'h1);
    check("byteenable", 32'(AM_BYTEENABLE), 32'hF);

    // read_ready in IDLE is ignored
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    steps(2);
    check("idle_rr_overrun", 32'(OVERRUN), 32'h0);
    check("idle_rr_select", 32'(select), 32'h0);

    // Zero-length run: FINISHED two cycles after the start edge, no writes
    saw_write = 1'b0;
    start = 1'b0;
    step();
    number_samples = 32'd0;
    start_address  = 32'h1234_5678;
    start = 1'b1;
    step();
    check("n0_finished_t1", 32'(FINISHED), 32'h0);
    step();
    check("n0_finished_t2", 32'(FINISHED), 32'h1);
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    steps(6);
    check("n0_no_write", 32'(saw_write), 32'h0);
    check("n0_done_overrun", 32'(OVERRUN), 32'h0);

    // Long run from an unaligned base with latency checks on the first frame
    launch(32'hDEADBEEF, 32'd10);
    check("t1_finished_clr", 32'(FINISHED), 32'h0);
    pulse_frame();
    check("t1_sel_a", 32'(select), 32'h2);
    step();
    check("t1_write_a", 32'(AM_WRITE), 32'h1);
    check("t1_addr_a", AM_ADDR, 32'hDEADBEEC);
    check("t1_data_a", AM_WRITEDATA, frame_a);
    if (WPF == 2) begin
      step();
      check("t1_sel_b", 32'(select), 32'h1);
      step();
      check("t1_write_b", 32'(AM_WRITE), 32'h1);
      check("t1_addr_b", AM_ADDR, 32'hDEADBEF0);
      check("t1_data_b", AM_WRITEDATA, frame_b);
    end
    drain(1'b0);
    for (int f = 1; f < 10; f++) begin
      check("t1_not_done", 32'(FINISHED), 32'h0);
      steps($urandom_range(0, 3));
      pulse_frame();
      drain(1'b0);
    end
    check("t1_finished", 32'(FINISHED), 32'h1);
    check("t1_accepted", 32'(accepted), 32'(10 * WPF));
    check("t1_select_idle", 32'(select), 32'h0);

    // Wait-states on the first write: request, address and data held
    launch(32'h1000_0000, 32'd1);
    AM_WAITREQUEST = 1'b1;
    pulse_frame();
    step();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_write", 32'(AM_WRITE), 32'h1);
      check("t2_hold_addr", AM_ADDR, 32'h1000_0000);
      check("t2_hold_data", AM_WRITEDATA, frame_a);
      step();
    end
    check("t2_none_yet", 32'(accepted), 32'h0);
    AM_WAITREQUEST = 1'b0;
    check("t2_still_write", 32'(AM_WRITE), 32'h1);
    drain(1'b0);
    check("t2_accepted", 32'(accepted), 32'(WPF));
    check("t2_finished", 32'(FINISHED), 32'h1);

    // read_ready during WRITE_A: frame dropped, OVERRUN set, count unchanged
    launch(32'h4000_0100, 32'd2);
    pulse_frame();
    step();
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    check("t4_overrun", 32'(OVERRUN), 32'h1);
    drain(1'b0);
    steps(3);
    check("t4_not_done", 32'(FINISHED), 32'h0);
    check("t4_accepted_1", 32'(accepted), 32'(WPF));
    pulse_frame();
    drain(1'b0);
    check("t4_finished", 32'(FINISHED), 32'h1);
    check("t4_accepted_2", 32'(accepted), 32'(2 * WPF));
    check("t4_sticky", 32'(OVERRUN), 32'h1);

    // Address wrap at the top of memory, random wait-states
    launch(32'hFFFF_FFF8, 32'd2);
    check("t5_overrun_clr", 32'(OVERRUN), 32'h0);
    check("t5_base", AM_ADDR, 32'hFFFF_FFF8);
    for (int f = 0; f < 2; f++) begin
      pulse_frame();
      drain(1'b1);
    end
    check("t5_accepted", 32'(accepted), 32'(2 * WPF));
    check("t5_finished", 32'(FINISHED), 32'h1);
    check("t5_end_addr", AM_ADDR, model_addr);

    // Asynchronous reset during the last write of a frame
    launch(32'h2000_0004, 32'd3);
    pulse_frame();
    step();
    if (WPF == 2) steps(2);
    check("t6_write_before", 32'(AM_WRITE), 32'h1);
    RESET = 1'b0;
    #2;
    check("t6_write_async", 32'(AM_WRITE), 32'h0);
    check("t6_addr_async", AM_ADDR, 32'h0);
    exp_q.delete();
    steps(2);
    RESET = 1'b1;
    saw_write = 1'b0;
    step();
    read_ready = 1'b1;
    step();
    read_ready = 1'b0;
    steps(5);
    check("t6_idle_no_write", 32'(saw_write), 32'h0);
    check("t6_idle_select", 32'(select), 32'h0);
    check("t6_idle_finished", 32'(FINISHED), 32'h0);
    launch(32'h3000_0000, 32'd1);
    pulse_frame();
    drain(1'b0);
    check("t6_relaunch_acc", 32'(accepted), 32'(WPF));
    check("t6_relaunch_fin", 32'(FINISHED), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
